// File: rtl/rd4_pkg.sv
// Shared types and helpers for the radix-4 serial subtractor.
// Holds digit width, FSM state type and digit/borrow result struct.
package rd4_pkg;

   localparam int DIGW = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [DIGW-1:0] d;
      logic            b;
   } dig_res_t;

   // One radix-4 digit of a - b - bin; the extra top bit is the borrow.
   function automatic dig_res_t sub_dig(
      input logic [DIGW-1:0] a,
      input logic [DIGW-1:0] b,
      input logic            bin
   );
      logic [DIGW:0] t;
      dig_res_t      r;
      t   = {1'b0, a} - {1'b0, b} - {{DIGW{1'b0}}, bin};
      r.d = t[DIGW-1:0];
      r.b = t[DIGW];
      return r;
   endfunction

endpackage

// File: rtl/rd4_sub_digit.sv
// Combinational radix-4 digit subtractor with borrow in/out.
// Ports: a, b (minuend/subtrahend digit), bin -> d (difference), bout.
module rd4_sub_digit
   import rd4_pkg::*;
(
   input  logic [DIGW-1:0] a,
   input  logic [DIGW-1:0] b,
   input  logic            bin,
   output logic [DIGW-1:0] d,
   output logic            bout
);

   dig_res_t r;

   assign r    = sub_dig(a, b, bin);
   assign d    = r.d;
   assign bout = r.b;

endmodule

// File: rtl/rd4_serial_sub.sv
// Digit-serial radix-4 subtractor, LSB-first, NDIG digits per word.
// Ports: clk, rst_n; in_valid/in_ready with a_dig, b_dig;
// out_valid/out_ready with diff_dig, out_last, borrow_out, out_zero.
module rd4_serial_sub
   import rd4_pkg::*;
#(
   parameter int NDIG = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DIGW-1:0] a_dig,
   input  logic [DIGW-1:0] b_dig,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DIGW-1:0] diff_dig,
   output logic            out_last,
   output logic            borrow_out,
   output logic            out_zero
);

   localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t          st;
   logic [CW-1:0]   cnt;
   logic            bq;
   logic            zacc;

   logic            in_xfer;
   logic            out_xfer;
   logic            bin;
   logic            is_last;
   logic            nz;
   logic [DIGW-1:0] dd;
   logic            db;

   assign in_ready = !out_valid || out_ready;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign is_last  = (cnt == LAST);

   // IDLE means digit 0 of a word: start with no borrow and a fresh
   // zero accumulator regardless of what the previous word left.
   assign bin = (st == RUN) ? bq : 1'b0;
   assign nz  = ((st == RUN) ? zacc : 1'b1) & (dd == '0);

   rd4_sub_digit u_dig (
      .a    (a_dig),
      .b    (b_dig),
      .bin  (bin),
      .d    (dd),
      .bout (db)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= IDLE;
         cnt        <= '0;
         bq         <= 1'b0;
         zacc       <= 1'b1;
         out_valid  <= 1'b0;
         diff_dig   <= '0;
         out_last   <= 1'b0;
         borrow_out <= 1'b0;
         out_zero   <= 1'b0;
      end else if (in_xfer) begin
         out_valid  <= 1'b1;
         diff_dig   <= dd;
         out_last   <= is_last;
         borrow_out <= is_last & db;
         out_zero   <= is_last & nz;
         if (is_last) begin
            st   <= IDLE;
            cnt  <= '0;
            bq   <= 1'b0;
            zacc <= 1'b1;
         end else begin
            st   <= RUN;
            cnt  <= cnt + 1'b1;
            bq   <= db;
            zacc <= nz;
         end
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rd4_serial_sub.sv
// Directed self-checking bench for rd4_serial_sub with NDIG=4.
// Covers reset, full words, back-to-back words, stall and mid-word reset.
module tb_rd4_serial_sub;

   localparam int NDIG = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] a_dig;
   logic [1:0] b_dig;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] diff_dig;
   logic       out_last;
   logic       borrow_out;
   logic       out_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rd4_serial_sub #(.NDIG(NDIG)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_dig      (a_dig),
      .b_dig      (b_dig),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff_dig   (diff_dig),
      .out_last   (out_last),
      .borrow_out (borrow_out),
      .out_zero   (out_zero)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b0;
         out_ready = 1'b1;
         a_dig = 2'($urandom);
         b_dig = 2'($urandom);
         step();
         chk({tag, " idle out_valid"}, out_valid, 8'd0);
      end
   endtask

   // Full-throughput word; e8 holds expected diff digits LSB-first.
   task automatic run_word(input string tag, input logic [7:0] a8,
                           input logic [7:0] b8, input logic [7:0] e8,
                           input logic eb, input logic ez);
      for (int i = 0; i < NDIG; i++) begin
         in_valid = 1'b1;
         out_ready = 1'b1;
         a_dig = a8[2*i +: 2];
         b_dig = b8[2*i +: 2];
         #1;
         chk($sformatf("%s in_ready%0d", tag, i), in_ready, 8'd1);
         step();
         chk($sformatf("%s out_valid%0d", tag, i), out_valid, 8'd1);
         chk($sformatf("%s diff%0d", tag, i), diff_dig, e8[2*i +: 2]);
         chk($sformatf("%s last%0d", tag, i), out_last,
             (i == NDIG - 1) ? 8'd1 : 8'd0);
         chk($sformatf("%s borrow%0d", tag, i), borrow_out,
             (i == NDIG - 1) ? {7'd0, eb} : 8'd0);
         chk($sformatf("%s zero%0d", tag, i), out_zero,
             (i == NDIG - 1) ? {7'd0, ez} : 8'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a_dig = 2'd0;
      b_dig = 2'd0;
      #12;
      chk("rst out_valid", out_valid, 8'd0);
      chk("rst diff", diff_dig, 8'd0);
      chk("rst last", out_last, 8'd0);
      chk("rst borrow", borrow_out, 8'd0);
      chk("rst zero", out_zero, 8'd0);
      chk("rst in_ready", in_ready, 8'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-rst in_ready", in_ready, 8'd1);

      // Garbage digits with in_valid low must be ignored.
      idle("pre", 2);

      // 0x5A - 0x3C = 0x1E
      run_word("w5a", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
      idle("w5a", 1);

      // 0x00 - 0x01 borrows; next word back-to-back must not inherit it.
      run_word("w00", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
      run_word("w10", 8'h10, 8'h00, 8'h10, 1'b0, 1'b0);
      idle("w10", 1);

      // Equal operands give all-zero digits.
      run_word("wa5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1);
      idle("wa5", 1);

      // Stall after digit 1 with in_valid held high.
      in_valid = 1'b1;
      out_ready = 1'b1;
      a_dig = 2'd2;
      b_dig = 2'd0;
      step();
      chk("st diff0", diff_dig, 8'd2);
      a_dig = 2'd2;
      b_dig = 2'd3;
      step();
      chk("st diff1", diff_dig, 8'd3);
      out_ready = 1'b0;
      a_dig = 2'd1;
      b_dig = 2'd3;
      #1;
      chk("st in_ready", in_ready, 8'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("st hold valid%0d", k), out_valid, 8'd1);
         chk($sformatf("st hold diff%0d", k), diff_dig, 8'd3);
         chk($sformatf("st hold rdy%0d", k), in_ready, 8'd0);
         chk($sformatf("st hold last%0d", k), out_last, 8'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("st resume rdy", in_ready, 8'd1);
      step();
      chk("st diff2", diff_dig, 8'd1);
      chk("st last2", out_last, 8'd0);
      a_dig = 2'd1;
      b_dig = 2'd0;
      step();
      chk("st diff3", diff_dig, 8'd0);
      chk("st last3", out_last, 8'd1);
      chk("st borrow3", borrow_out, 8'd0);
      chk("st zero3", out_zero, 8'd0);
      idle("st", 1);

      // Reset after two digits discards the partial word.
      in_valid = 1'b1;
      out_ready = 1'b1;
      a_dig = 2'd2;
      b_dig = 2'd0;
      step();
      a_dig = 2'd2;
      b_dig = 2'd3;
      step();
      chk("mr pre valid", out_valid, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr out_valid", out_valid, 8'd0);
      chk("mr in_ready", in_ready, 8'd1);
      chk("mr diff", diff_dig, 8'd0);
      in_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mr post in_ready", in_ready, 8'd1);
      run_word("mr", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
      idle("mr", 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/rd4_serial_sub.md
RD4_SERIAL_SUB -- requirements
Module: rd4_serial_sub

Interface
REQ-001 SHALL have parameter NDIG, default 8, giving radix-4 digits per operand word (word width 2*NDIG bits); legal range 2..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, the upstream digit pair is valid.
REQ-005 SHALL have port in_ready, output, 1, the block accepts a digit pair this cycle.
REQ-006 SHALL have port a_dig, input, 2, minuend digit, LSB-first order.
REQ-007 SHALL have port b_dig, input, 2, subtrahend digit, LSB-first order.
REQ-008 SHALL have port out_valid, output, 1, diff_dig/out_last/borrow_out/out_zero are valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the output digit.
REQ-010 SHALL have port diff_dig, output, 2, difference digit (A-B mod 4 with borrow).
REQ-011 SHALL have port out_last, output, 1, marks digit NDIG-1 of a word.
REQ-012 SHALL have port borrow_out, output, 1, final borrow (A<B unsigned); meaningful only with out_last.
REQ-013 SHALL have port out_zero, output, 1, all NDIG difference digits were zero; meaningful only with out_last.

Function
REQ-014 SHALL transfer input when in_valid and in_ready are both 1, and output when out_valid and out_ready are both 1.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (single output register, no combinational path from in_valid to out_valid).
REQ-016 SHALL compute per accepted digit: t = a_dig - b_dig - bq; diff_dig = t mod 4; new bq = 1 if t<0, where bq is the stored borrow.
REQ-017 SHALL use bq = 0 for digit index 0 of every word, regardless of the previous word's final borrow.
REQ-018 SHALL present the result in the output register one cycle after acceptance (latency 1), held stable while out_valid && !out_ready.
REQ-019 SHALL keep a digit counter 0..NDIG-1, incremented on each input transfer, wrapping to 0 after NDIG-1.
REQ-020 SHALL implement FSM IDLE (counter 0, no word in progress) -> RUN on first input transfer; RUN -> IDLE on transfer of digit NDIG-1; RUN otherwise holds.
REQ-021 SHALL set out_last with the digit at counter NDIG-1; borrow_out = new bq of that digit; out_zero = AND of (diff_dig==0) over the word.
REQ-022 SHALL drive borrow_out and out_zero to 0 when out_last is 0.
REQ-023 SHALL allow back-to-back words with no idle cycle: digit NDIG-1 of word k and digit 0 of word k+1 on consecutive cycles at full throughput.
REQ-024 SHALL accept a new input in the same cycle an output is consumed (simultaneous in/out transfer), sustaining one digit per cycle.
REQ-025 SHALL ignore a_dig/b_dig when in_valid is 0 or in_ready is 0; state unchanged.

Reset
REQ-026 SHALL on rst_n low asynchronously clear: out_valid=0, diff_dig=0, out_last=0, borrow_out=0, out_zero=0, bq=0, counter=0, zero accumulator=1, FSM=IDLE.
REQ-027 SHALL drive in_ready=1 while in reset and on the first cycle after release.
REQ-028 SHALL discard any partially received word on reset; the first transfer after release is digit 0 of a new word.

Structure
REQ-029 SHALL place digit width constant (2), FSM state typedef {IDLE, RUN}, and digit/borrow result struct in shared package rd4_pkg.
REQ-030 SHALL instantiate one combinational sub-module rd4_sub_digit (a, b, bin -> d, bout) for REQ-016; all state in the top level.

Verification (NDIG=4)
REQ-031 SHALL verify A=0x5A, B=0x3C (a=2,2,1,1; b=0,3,3,0) -> diff 2,3,1,0, out_last on 4th, borrow_out=0, out_zero=0.
REQ-032 SHALL verify A=0x00, B=0x01 -> diff 3,3,3,3, borrow_out=1, out_zero=0; next word A=0x10,B=0x00 back-to-back -> 0,0,1,0, borrow_out=0 (no borrow leak).
REQ-033 SHALL verify A=B=0xA5 -> diff 0,0,0,0, out_zero=1, borrow_out=0.
REQ-034 SHALL verify out_ready low 3 cycles after digit 1 with in_valid held high -> in_ready=0 during stall, diff_dig stable, no digit lost or duplicated.
REQ-035 SHALL verify rst_n low after 2 digits of a word -> out_valid=0 immediately; then full word A=0x5A,B=0x3C yields REQ-031 results.
